cmos_frame_capture: RTL and testbench

//  Captures the OV7725 8-bit DVP stream and packs byte pairs into RGB565 pixels.

---
 rtl/cmos_frame_capture.sv | 154 +++++++++++++++
 tb/tb_cmos_frame_capture.sv | 332 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/cmos_frame_capture.sv
// OV7725 DVP capture: packs high/low byte pairs into RGB565 pixels once the sensor
// has settled, and tracks line/pixel position with per-line and per-frame geometry checks.
module cmos_frame_capture #(
    parameter logic [3:0] WAIT_FRAME = 4'd10,
    parameter logic [9:0] H_PIXEL    = 10'd640,
    parameter logic [8:0] V_PIXEL    = 9'd480
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        init_done,
    input  logic        cam_vsync,
    input  logic        cam_href,
    input  logic [7:0]  cam_data,
    output logic        frame_vsync,
    output logic        frame_href,
    output logic        frame_valid,
    output logic [15:0] frame_data,
    output logic [9:0]  pix_x,
    output logic [8:0]  pix_y,
    output logic        frame_done,
    output logic        line_err,
    output logic        frame_err
);

    typedef struct packed {
        logic        vld;
        logic [15:0] data;
    } pix_t;

    logic       vsync_d0, vsync_d1;
    logic       href_d0, href_d1;
    logic [7:0] data_d0;
    logic       vs_rise, hr_fall;

    logic [3:0] settle_cnt;
    logic       frame_en;

    logic       byte_flag;
    logic [7:0] hi_byte;
    pix_t       pix_s;
    logic       pix_fire;

    logic [9:0] pix_x_inc;
    logic [8:0] pix_y_acc;
    logic       line_bad;
    logic       err_sticky;

    assign vs_rise  = vsync_d0 & ~vsync_d1;
    assign hr_fall  = ~href_d0 & href_d1;
    assign pix_fire = href_d0 & byte_flag;

    assign frame_vsync = vsync_d1 & frame_en;
    assign frame_href  = href_d1 & frame_en;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            vsync_d0 <= 1'b0;
            vsync_d1 <= 1'b0;
            href_d0  <= 1'b0;
            href_d1  <= 1'b0;
            data_d0  <= 8'd0;
        end else begin
            vsync_d0 <= cam_vsync;
            vsync_d1 <= vsync_d0;
            href_d0  <= cam_href;
            href_d1  <= href_d0;
            data_d0  <= cam_data;
        end
    end

    // Enable only on a vsync rise so the first emitted pixel is always the start of a frame.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            settle_cnt <= 4'd0;
            frame_en   <= 1'b0;
        end else if (!init_done) begin
            settle_cnt <= 4'd0;
            frame_en   <= 1'b0;
        end else if (vs_rise && settle_cnt != WAIT_FRAME) begin
            settle_cnt <= settle_cnt + 4'd1;
            if (settle_cnt + 4'd1 == WAIT_FRAME)
                frame_en <= 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            byte_flag <= 1'b0;
            hi_byte   <= 8'd0;
            pix_s     <= '0;
        end else begin
            byte_flag <= href_d0 ? ~byte_flag : 1'b0;
            if (href_d0 && !byte_flag)
                hi_byte <= data_d0;
            pix_s.vld <= pix_fire;
            if (pix_fire)
                pix_s.data <= {hi_byte, data_d0};
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            frame_valid <= 1'b0;
            frame_data  <= 16'd0;
        end else begin
            frame_valid <= pix_s.vld & frame_en;
            if (pix_s.vld && frame_en)
                frame_data <= pix_s.data;
        end
    end

    // Position counts pixels as they are packed, so the last pixel of a line is
    // already included when hr_fall arrives one cycle before its frame_valid.
    always_comb begin
        pix_x_inc = (pix_x == 10'h3FF) ? pix_x : pix_x + 10'd1;
        pix_y_acc = pix_y;
        if (hr_fall && pix_x != 10'd0 && pix_y != 9'h1FF)
            pix_y_acc = pix_y + 9'd1;
        line_bad  = hr_fall & frame_en & (pix_x != H_PIXEL);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pix_x <= 10'd0;
            pix_y <= 9'd0;
        end else begin
            if (vs_rise || hr_fall)
                pix_x <= 10'd0;
            else if (pix_fire)
                pix_x <= pix_x_inc;
            pix_y <= vs_rise ? 9'd0 : pix_y_acc;
        end
    end

    // A line error on the same cycle as the frame boundary still counts toward this frame.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            line_err   <= 1'b0;
            err_sticky <= 1'b0;
            frame_done <= 1'b0;
            frame_err  <= 1'b0;
        end else begin
            line_err   <= line_bad;
            frame_done <= vs_rise & frame_en;
            if (vs_rise && frame_en) begin
                frame_err  <= (pix_y_acc != V_PIXEL) | err_sticky | line_bad;
                err_sticky <= 1'b0;
            end else if (line_bad) begin
                err_sticky <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_cmos_frame_capture.sv
// Bench for cmos_frame_capture: small frame geometry, scoreboard of expected pixels
// filled while bytes are driven and drained by a monitor on frame_valid.
module tb_cmos_frame_capture;
    localparam int H  = 8;
    localparam int V  = 4;
    localparam int WF = 10;

    logic        clk = 1'b0;
    logic        rst;
    logic        init_done;
    logic        cam_vsync;
    logic        cam_href;
    logic [7:0]  cam_data;
    logic        frame_vsync, frame_href, frame_valid;
    logic [15:0] frame_data;
    logic [9:0]  pix_x;
    logic [8:0]  pix_y;
    logic        frame_done, line_err, frame_err;

    cmos_frame_capture #(
        .WAIT_FRAME(4'(WF)),
        .H_PIXEL   (10'(H)),
        .V_PIXEL   (9'(V))
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .init_done  (init_done),
        .cam_vsync  (cam_vsync),
        .cam_href   (cam_href),
        .cam_data   (cam_data),
        .frame_vsync(frame_vsync),
        .frame_href (frame_href),
        .frame_valid(frame_valid),
        .frame_data (frame_data),
        .pix_x      (pix_x),
        .pix_y      (pix_y),
        .frame_done (frame_done),
        .line_err   (line_err),
        .frame_err  (frame_err)
    );

    always #5 clk = ~clk;

    int          checks = 0;
    int          failures = 0;
    logic [15:0] sb[$];
    int          vs_count = 0;
    logic [7:0]  hi_b;
    int          vcount = 0, lerr_cnt = 0, fd_cnt = 0;
    logic        last_ferr = 1'b0;
    logic        prev_fv = 1'b0;

    always @(negedge clk) begin
        if (!rst) begin
            if (frame_valid) begin
                vcount++;
                checks++;
                if (prev_fv) begin
                    failures++;
                    $display("FAIL valid_back_to_back got=1 want=0");
                end
                if (sb.size() == 0) begin
                    failures++;
                    $display("FAIL unexpected_valid data=%h want=no_valid", frame_data);
                end else begin
                    logic [15:0] e;
                    e = sb.pop_front();
                    if (frame_data !== e) begin
                        failures++;
                        $display("FAIL pixel_data got=%h want=%h", frame_data, e);
                    end
                end
            end
            if (line_err) lerr_cnt++;
            if (frame_done) begin
                fd_cnt++;
                last_ferr = frame_err;
            end
        end
        prev_fv = frame_valid;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog got=timeout want=finish");
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures + 1);
        $fatal(1);
    end

    function automatic bit exp_en();
        return init_done && (vs_count >= WF);
    endfunction

    task automatic send_byte(input int b);
        @(negedge clk);
        cam_href = 1'b1;
        cam_data = 8'($urandom_range(0, 255));
        if (b % 2 == 0) hi_b = cam_data;
        else if (exp_en()) sb.push_back({hi_b, cam_data});
    endtask

    task automatic send_line(input int nbytes);
        for (int b = 0; b < nbytes; b++) send_byte(b);
        @(negedge clk);
        cam_href = 1'b0;
        cam_data = 8'd0;
        repeat (4) @(negedge clk);
    endtask

    task automatic send_vsync();
        @(negedge clk);
        cam_vsync = 1'b1;
        vs_count++;
        repeat (2) @(negedge clk);
        cam_vsync = 1'b0;
        repeat (4) @(negedge clk);
    endtask

    task automatic send_frame(input int nlines);
        for (int l = 0; l < nlines; l++) send_line(2 * H);
        send_vsync();
    endtask

    task automatic test_reset();
        logic [40:0] outs;
        rst = 1'b1; init_done = 1'b1; cam_vsync = 1'b0; cam_href = 1'b0; cam_data = 8'd0;
        #1;
        outs = {frame_vsync, frame_href, frame_valid, frame_data, pix_x, pix_y,
                frame_done, line_err, frame_err};
        checks++;
        if (outs !== '0) begin
            failures++;
            $display("FAIL reset_outputs got=%h want=0", outs);
        end
        repeat (3) @(negedge clk);
        rst = 1'b0;
        vs_count = 0;
    endtask

    task automatic test_settle();
        int v0, d0, l0;
        l0 = lerr_cnt;
        for (int f = 1; f <= WF + 2; f++) begin
            v0 = vcount; d0 = fd_cnt;
            send_frame(V);
            checks++;
            if (vcount - v0 != ((f > WF) ? H * V : 0)) begin
                failures++;
                $display("FAIL settle_valid_count frame=%0d got=%0d want=%0d", f, vcount - v0,
                         (f > WF) ? H * V : 0);
            end
            checks++;
            if (fd_cnt - d0 != ((f > WF) ? 1 : 0)) begin
                failures++;
                $display("FAIL settle_frame_done frame=%0d got=%0d want=%0d", f, fd_cnt - d0,
                         (f > WF) ? 1 : 0);
            end
        end
        checks++;
        if (last_ferr !== 1'b0) begin
            failures++;
            $display("FAIL settle_frame_err got=%b want=0", last_ferr);
        end
        checks++;
        if (lerr_cnt != l0) begin
            failures++;
            $display("FAIL settle_line_err got=%0d want=0", lerr_cnt - l0);
        end
    endtask

    task automatic test_pack();
        int d0, l0;
        d0 = fd_cnt; l0 = lerr_cnt;
        checks++;
        if (pix_x !== 10'd0) begin
            failures++;
            $display("FAIL pack_pix_x_start got=%0d want=0", pix_x);
        end
        @(negedge clk); cam_href = 1'b1; cam_data = 8'hF8;
        @(negedge clk); cam_data = 8'h1F; sb.push_back(16'hF81F);
        @(posedge clk);
        @(negedge clk); cam_href = 1'b0; cam_data = 8'd0;
        @(posedge clk); #1;
        checks++;
        if (frame_valid !== 1'b0 || pix_x !== 10'd1) begin
            failures++;
            $display("FAIL pack_latency_1clk got=valid%b/x%0d want=valid0/x1", frame_valid, pix_x);
        end
        @(posedge clk); #1;
        checks++;
        if (frame_valid !== 1'b1 || frame_data !== 16'hF81F) begin
            failures++;
            $display("FAIL pack_latency_2clk got=valid%b/%h want=valid1/f81f", frame_valid, frame_data);
        end
        repeat (4) @(negedge clk);
        send_vsync();
        checks++;
        if (fd_cnt - d0 != 1 || last_ferr !== 1'b1 || lerr_cnt - l0 != 1) begin
            failures++;
            $display("FAIL pack_frame got=done%0d/err%b/lerr%0d want=done1/err1/lerr1",
                     fd_cnt - d0, last_ferr, lerr_cnt - l0);
        end
    endtask

    task automatic test_odd_line();
        int l0;
        l0 = lerr_cnt;
        send_line(2 * H);
        send_line(2 * H - 1);
        send_line(2 * H);
        send_line(2 * H);
        checks++;
        if (lerr_cnt - l0 != 1 || pix_y !== 9'(V)) begin
            failures++;
            $display("FAIL odd_line got=lerr%0d/y%0d want=lerr1/y%0d", lerr_cnt - l0, pix_y, V);
        end
        send_vsync();
        checks++;
        if (last_ferr !== 1'b1) begin
            failures++;
            $display("FAIL odd_line_frame_err got=%b want=1", last_ferr);
        end
    endtask

    task automatic test_short_frame();
        int l0;
        l0 = lerr_cnt;
        for (int l = 0; l < V - 1; l++) send_line(2 * H);
        checks++;
        if (pix_y !== 9'(V - 1)) begin
            failures++;
            $display("FAIL short_pix_y got=%0d want=%0d", pix_y, V - 1);
        end
        send_vsync();
        checks++;
        if (last_ferr !== 1'b1) begin
            failures++;
            $display("FAIL short_frame_err got=%b want=1", last_ferr);
        end
        send_frame(V);
        checks++;
        if (last_ferr !== 1'b0 || lerr_cnt != l0) begin
            failures++;
            $display("FAIL full_frame_err got=err%b/lerr%0d want=err0/lerr0", last_ferr, lerr_cnt - l0);
        end
    endtask

    task automatic resettle(input string tag);
        int v0, d0;
        v0 = vcount; d0 = fd_cnt;
        for (int f = 1; f <= WF; f++) send_frame(V);
        checks++;
        if (vcount != v0 || fd_cnt != d0) begin
            failures++;
            $display("FAIL %s_settle got=valid%0d/done%0d want=0/0", tag, vcount - v0, fd_cnt - d0);
        end
        v0 = vcount;
        send_frame(V);
        checks++;
        if (vcount - v0 != H * V || fd_cnt - d0 != 1 || last_ferr !== 1'b0) begin
            failures++;
            $display("FAIL %s_resume got=valid%0d/done%0d/err%b want=%0d/1/0", tag,
                     vcount - v0, fd_cnt - d0, last_ferr, H * V);
        end
    endtask

    task automatic test_reset_mid();
        logic [40:0] outs;
        for (int b = 0; b < 5; b++) send_byte(b);
        @(negedge clk);
        rst = 1'b1;
        #1;
        outs = {frame_vsync, frame_href, frame_valid, frame_data, pix_x, pix_y,
                frame_done, line_err, frame_err};
        checks++;
        if (outs !== '0) begin
            failures++;
            $display("FAIL reset_mid_outputs got=%h want=0", outs);
        end
        sb.delete();
        cam_href = 1'b0; cam_data = 8'd0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        vs_count = 0;
        resettle("reset_mid");
    endtask

    task automatic test_init_drop();
        int v0, d0;
        d0 = fd_cnt;
        for (int b = 0; b < 6; b++) send_byte(b);
        @(negedge clk);
        init_done = 1'b0;
        cam_data = 8'($urandom_range(0, 255));
        @(negedge clk);
        v0 = vcount;
        cam_data = 8'($urandom_range(0, 255));
        for (int b = 8; b < 2 * H; b++) send_byte(b);
        @(negedge clk); cam_href = 1'b0;
        repeat (4) @(negedge clk);
        for (int l = 1; l < V; l++) send_line(2 * H);
        send_vsync();
        checks++;
        if (vcount != v0 || fd_cnt != d0) begin
            failures++;
            $display("FAIL init_drop_stop got=valid%0d/done%0d want=0/0", vcount - v0, fd_cnt - d0);
        end
        sb.delete();
        @(negedge clk);
        init_done = 1'b1;
        vs_count = 0;
        resettle("init_drop");
    endtask

    initial begin
        test_reset();
        test_settle();
        test_pack();
        test_odd_line();
        test_short_frame();
        test_reset_mid();
        test_init_drop();
        repeat (10) @(negedge clk);
        checks++;
        if (sb.size() != 0) begin
            failures++;
            $display("FAIL scoreboard_drain got=%0d want=0", sb.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
